cpu_sram_arbiter: RTL

Merges the core's instruction and data sram-like master ports onto one shared sram-like slave port toward the memory bridge. Forwards one request per cycle with data-side priority and a grant lock while a request is unaccepted. Tracks outstanding transactions in an in-order owner FIFO so each slave data_ok/rdata returns to the correct master. Sits between the CPU top and the single-port memory/AXI bridge.

---
 rtl/cpu_sram_arbiter_if.sv | 22 ++
 rtl/cpu_sram_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/cpu_sram_arbiter_if.sv
// One sram-like bus: request channel from master, handshakes and read data back.
interface cpu_sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// Merges the instruction and data sram-like masters onto one sram-like slave.
// Data side wins ties; a request left unaccepted locks the grant to its owner.
// An in-order owner FIFO steers each response back to the master that issued it.
module cpu_sram_arbiter #(
  parameter int OT_DEPTH = 4,
  parameter int PTR_W    = 2
) (
  input  logic            clk,
  input  logic            resetn,
  cpu_sram_arbiter_if.slave  inst,
  cpu_sram_arbiter_if.slave  data,
  cpu_sram_arbiter_if.master mem
);

  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(OT_DEPTH);

  logic [OT_DEPTH-1:0] owner_q;     // 0 = inst, 1 = data
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W:0]      count;
  logic                lock;
  logic                lock_owner;

  logic sel;
  logic sel_req;
  logic full;
  logic push;
  logic pop;
  logic pop_owner;

  // Grant select: a pending lock overrides priority, otherwise data first.
  assign sel       = lock ? lock_owner : data.req;
  assign sel_req   = sel ? data.req : inst.req;
  assign full      = (count == DEPTH);
  assign push      = mem.req & mem.addr_ok;
  assign pop       = resetn & mem.data_ok & (count != '0);
  assign pop_owner = owner_q[rd_ptr];

  // Forwarded request; everything forced low while in reset.
  assign mem.req   = resetn & sel_req & ~full;
  assign mem.wr    = resetn & (sel ? data.wr : inst.wr);
  assign mem.size  = {2{resetn}}  & (sel ? data.size  : inst.size);
  assign mem.wstrb = {4{resetn}}  & (sel ? data.wstrb : inst.wstrb);
  assign mem.addr  = {32{resetn}} & (sel ? data.addr  : inst.addr);
  assign mem.wdata = {32{resetn}} & (sel ? data.wdata : inst.wdata);

  // Handshakes back to the masters; responses go to the FIFO head owner.
  assign inst.addr_ok = push & ~sel;
  assign data.addr_ok = push &  sel;
  assign inst.data_ok = pop & ~pop_owner;
  assign data.data_ok = pop &  pop_owner;
  assign inst.rdata   = {32{resetn}} & mem.rdata;
  assign data.rdata   = {32{resetn}} & mem.rdata;

  // Owner FIFO, outstanding count and grant lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      lock       <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      // Hold the grant on an unaccepted request; a dropped request
      // (protocol violation) releases it so the other side is not starved.
      if (mem.req && !mem.addr_ok) begin
        lock       <= 1'b1;
        lock_owner <= sel;
      end else if (mem.req && mem.addr_ok) begin
        lock <= 1'b0;
      end else if (lock && !sel_req) begin
        lock <= 1'b0;
      end
    end
  end

endmodule
